// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM for a stack-based infix calculator datapath.
// Scans the expression ROM, builds numbers, pushes operands/operators and
// runs reductions until '#', leaving the final value on the operand stack.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   start                    begin evaluation, sampled only in IDLE
//   is_operand               current ROM char is a digit
//   is_operator              current ROM char is an operator
//   is_hash                  current ROM char is the '#' terminator
//   is_lt                    incoming operator must reduce the stacked one
//   is_empty                 operator stack empty
//   num0_en/num1_en/num2_en  latch current digit into slot 0/1/2
//   num_clr                  clear digit slots
//   mode                     digit count minus 1 for the converter
//   index_cnt                advance ROM index
//   sel                      operand push source: 0 number, 1 ALU result
//   operand_push/pop         operand stack strobes
//   operator_push/pop        operator stack strobes
//   op1_en/op2_en            latch top operand into ALU operand regs
//   operator_en              latch top operator into ALU
//   result_en                ALU writes its result register
//   busy/done/error          status
module calc_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int MAX_LEN     = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_operand,
    input  logic       is_operator,
    input  logic       is_hash,
    input  logic       is_lt,
    input  logic       is_empty,
    output logic       num0_en,
    output logic       num1_en,
    output logic       num2_en,
    output logic       num_clr,
    output logic [1:0] mode,
    output logic       index_cnt,
    output logic       sel,
    output logic       operand_push,
    output logic       operand_pop,
    output logic       operator_push,
    output logic       operator_pop,
    output logic       op1_en,
    output logic       op2_en,
    output logic       operator_en,
    output logic       result_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int OCC_W = $clog2(STACK_DEPTH + 1);
    localparam int CH_W  = $clog2(MAX_LEN + 1);
    localparam int EX_W  = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_DIGIT,
        S_OPR_PUSH,
        S_PUSH_NUM,
        S_RED_OP2,
        S_RED_OP1,
        S_RED_OPR,
        S_EXEC,
        S_PUSH_RES,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic       num0;
        logic       num1;
        logic       num2;
        logic       clr;
        logic [1:0] mode;
        logic       idx;
        logic       sel;
        logic       opd_push;
        logic       opd_pop;
        logic       opr_push;
        logic       opr_pop;
        logic       op1;
        logic       op2;
        logic       opr_en;
        logic       res;
        logic       busy;
        logic       done;
        logic       error;
    } ctl_t;

    state_t           state;
    state_t           nxt;
    logic [1:0]       cnt;
    logic [OCC_W-1:0] opd_occ;
    logic [OCC_W-1:0] opr_occ;
    logic [CH_W-1:0]  char_cnt;
    logic [EX_W-1:0]  ex_cnt;
    logic [EX_W-1:0]  ex_nxt;
    logic             ret_drain;
    ctl_t             ctl;

    logic opd_full;
    logic opr_full;
    logic opd_few;
    logic last_char;
    logic ex_last;

    assign opd_full  = (opd_occ == OCC_W'(STACK_DEPTH));
    assign opr_full  = (opr_occ == OCC_W'(STACK_DEPTH));
    assign opd_few   = (opd_occ < OCC_W'(2));
    assign last_char = (char_cnt == CH_W'(MAX_LEN - 1));
    assign ex_last   = (ex_cnt == EX_W'(EXEC_CYCLES - 1));

    // Strobes for the cycle spent in state s. Outputs are registered
    // from the next state, so they line up with the state itself.
    function automatic ctl_t decode(
        input state_t     s,
        input logic [1:0] c,
        input logic       res_last
    );
        ctl_t d;
        d = '0;
        unique case (s)
            S_DIGIT: begin
                d.num0 = (c == 2'd0);
                d.num1 = (c == 2'd1);
                d.num2 = (c == 2'd2);
                d.idx  = 1'b1;
            end
            S_OPR_PUSH: begin
                d.opr_push = 1'b1;
                d.idx      = 1'b1;
            end
            S_PUSH_NUM: begin
                d.opd_push = 1'b1;
                d.clr      = 1'b1;
                d.mode     = c - 2'd1;
            end
            S_RED_OP2: begin
                d.op2     = 1'b1;
                d.opd_pop = 1'b1;
            end
            S_RED_OP1: begin
                d.op1     = 1'b1;
                d.opd_pop = 1'b1;
            end
            S_RED_OPR: begin
                d.opr_en  = 1'b1;
                d.opr_pop = 1'b1;
            end
            S_EXEC:     d.res = res_last;
            S_PUSH_RES: begin
                d.opd_push = 1'b1;
                d.sel      = 1'b1;
            end
            S_DONE:  d.done  = 1'b1;
            S_ERROR: d.error = 1'b1;
            default: ;
        endcase
        d.busy = !(s inside {S_IDLE, S_DONE, S_ERROR});
        return d;
    endfunction

    always_comb begin
        nxt    = state;
        ex_nxt = '0;
        unique case (state)
            S_IDLE: if (start) nxt = S_SCAN;
            S_SCAN: begin
                unique case (1'b1)
                    is_operand:
                        nxt = (cnt == 2'd3) ? S_ERROR : S_DIGIT;
                    is_operator: begin
                        // A pending number is pushed first; the
                        // operator is re-examined on return.
                        if (cnt != 2'd0)
                            nxt = opd_full ? S_ERROR : S_PUSH_NUM;
                        else if (!is_empty && is_lt)
                            nxt = opd_few ? S_ERROR : S_RED_OP2;
                        else
                            nxt = opr_full ? S_ERROR : S_OPR_PUSH;
                    end
                    is_hash: begin
                        if (cnt != 2'd0)
                            nxt = opd_full ? S_ERROR : S_PUSH_NUM;
                        else
                            nxt = S_DRAIN;
                    end
                    default: nxt = S_ERROR;
                endcase
            end
            S_DIGIT, S_OPR_PUSH:
                nxt = last_char ? S_ERROR : S_SCAN;
            S_PUSH_NUM: nxt = S_SCAN;
            S_RED_OP2:  nxt = S_RED_OP1;
            S_RED_OP1:  nxt = S_RED_OPR;
            S_RED_OPR:  nxt = S_EXEC;
            S_EXEC: begin
                if (ex_last) begin
                    nxt = opd_full ? S_ERROR : S_PUSH_RES;
                end else begin
                    ex_nxt = ex_cnt + EX_W'(1);
                end
            end
            S_PUSH_RES: nxt = ret_drain ? S_DRAIN : S_SCAN;
            S_DRAIN: begin
                if (!is_empty)
                    nxt = opd_few ? S_ERROR : S_RED_OP2;
                else if (opd_occ == OCC_W'(1))
                    nxt = S_DONE;
                else
                    nxt = S_ERROR;
            end
            S_DONE:  nxt = S_DONE;
            S_ERROR: nxt = S_ERROR;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            opd_occ   <= '0;
            opr_occ   <= '0;
            char_cnt  <= '0;
            ex_cnt    <= '0;
            ret_drain <= 1'b0;
            ctl       <= '0;
        end else begin
            state  <= nxt;
            ex_cnt <= ex_nxt;
            ctl    <= decode(nxt, cnt,
                             ex_nxt == EX_W'(EXEC_CYCLES - 1));
            // Counters track the strobes issued in the current state.
            unique case (state)
                S_SCAN:  ret_drain <= 1'b0;
                S_DRAIN: ret_drain <= 1'b1;
                S_DIGIT: begin
                    cnt      <= cnt + 2'd1;
                    char_cnt <= char_cnt + CH_W'(1);
                end
                S_OPR_PUSH: begin
                    opr_occ  <= opr_occ + OCC_W'(1);
                    char_cnt <= char_cnt + CH_W'(1);
                end
                S_PUSH_NUM: begin
                    cnt     <= 2'd0;
                    opd_occ <= opd_occ + OCC_W'(1);
                end
                S_RED_OP2, S_RED_OP1:
                    opd_occ <= opd_occ - OCC_W'(1);
                S_RED_OPR:
                    opr_occ <= opr_occ - OCC_W'(1);
                S_PUSH_RES:
                    opd_occ <= opd_occ + OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign num0_en       = ctl.num0;
    assign num1_en       = ctl.num1;
    assign num2_en       = ctl.num2;
    assign num_clr       = ctl.clr;
    assign mode          = ctl.mode;
    assign index_cnt     = ctl.idx;
    assign sel           = ctl.sel;
    assign operand_push  = ctl.opd_push;
    assign operand_pop   = ctl.opd_pop;
    assign operator_push = ctl.opr_push;
    assign operator_pop  = ctl.opr_pop;
    assign op1_en        = ctl.op1;
    assign op2_en        = ctl.op2;
    assign operator_en   = ctl.opr_en;
    assign result_en     = ctl.res;
    assign busy          = ctl.busy;
    assign done          = ctl.done;
    assign error         = ctl.error;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: behavioural ROM/stack/ALU datapath around the
// sequencer, with results compared against an arithmetic evaluator.
`timescale 1ns/1ps
module tb_calc_sequencer;

    localparam int EXEC_CYCLES = 1;
    localparam int C_HASH = 10;
    localparam int C_ADD  = 20;
    localparam int C_SUB  = 21;
    localparam int C_MUL  = 22;
    localparam int C_DIV  = 23;
    localparam int C_BAD  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic       is_operand, is_operator, is_hash, is_lt, is_empty;
    logic       num0_en, num1_en, num2_en, num_clr;
    logic [1:0] mode;
    logic       index_cnt, sel;
    logic       operand_push, operand_pop, operator_push, operator_pop;
    logic       op1_en, op2_en, operator_en, result_en;
    logic       busy, done, error;

    calc_sequencer #(
        .STACK_DEPTH(8),
        .EXEC_CYCLES(EXEC_CYCLES),
        .MAX_LEN(128)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .is_operand(is_operand), .is_operator(is_operator),
        .is_hash(is_hash), .is_lt(is_lt), .is_empty(is_empty),
        .num0_en(num0_en), .num1_en(num1_en), .num2_en(num2_en),
        .num_clr(num_clr), .mode(mode), .index_cnt(index_cnt),
        .sel(sel), .operand_push(operand_push),
        .operand_pop(operand_pop), .operator_push(operator_push),
        .operator_pop(operator_pop), .op1_en(op1_en), .op2_en(op2_en),
        .operator_en(operator_en), .result_en(result_en),
        .busy(busy), .done(done), .error(error)
    );

    // ---------------- behavioural datapath ----------------
    int         rom [128];
    logic [6:0] idx;
    int         dstk [16];
    int         ostk [16];
    int         dsp, osp;
    int         d0, d1, d2, op1, op2, opr, result;
    int         cur, dtop, otop, conv;
    logic [19:0] outs;

    // monitors
    int cyc, n_num1, n_push, n_pop, n_res;
    int first_mode, first_val, first_res, t_op2, t_res;

    int errors = 0;
    int checks = 0;

    function automatic int prec(input int c);
        return (c == C_MUL || c == C_DIV) ? 2 : 1;
    endfunction

    function automatic int alu(input int a, input int b, input int o);
        case (o)
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_MUL:   return a * b;
            C_DIV:   return (b == 0) ? 0 : a / b;
            default: return 0;
        endcase
    endfunction

    always_comb begin
        cur  = rom[idx];
        dtop = (dsp > 0) ? dstk[dsp-1] : 0;
        otop = (osp > 0) ? ostk[osp-1] : 0;
        is_operand  = (cur >= 0) && (cur <= 9);
        is_hash     = (cur == C_HASH);
        is_operator = (cur >= 20) && (cur <= 30);
        is_empty    = (osp == 0);
        is_lt       = is_operator && (osp > 0) &&
                      (prec(cur) <= prec(otop));
        case (mode)
            2'd0:    conv = d0;
            2'd1:    conv = d0 * 10 + d1;
            2'd2:    conv = d0 * 100 + d1 * 10 + d2;
            default: conv = d0;
        endcase
    end

    assign outs = {num0_en, num1_en, num2_en, num_clr, mode, index_cnt,
                   sel, operand_push, operand_pop, operator_push,
                   operator_pop, op1_en, op2_en, operator_en, result_en,
                   busy, done, error};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0; dsp <= 0; osp <= 0;
            d0 <= 0; d1 <= 0; d2 <= 0;
            op1 <= 0; op2 <= 0; opr <= 0; result <= 0;
            cyc <= 0; n_num1 <= 0; n_push <= 0; n_pop <= 0; n_res <= 0;
            first_mode <= -1; first_val <= -1; first_res <= -1;
            t_op2 <= -1; t_res <= -1;
        end else begin
            cyc <= cyc + 1;
            if (index_cnt) idx <= idx + 7'd1;
            if (num0_en) d0 <= cur;
            if (num1_en) begin d1 <= cur; n_num1 <= n_num1 + 1; end
            if (num2_en) d2 <= cur;
            if (num_clr) begin d0 <= 0; d1 <= 0; d2 <= 0; end
            if (op2_en) begin
                op2 <= dtop;
                if (t_op2 < 0) t_op2 <= cyc;
            end
            if (op1_en) op1 <= dtop;
            if (operand_pop) begin
                n_pop <= n_pop + 1;
                if (dsp > 0) dsp <= dsp - 1;
            end
            if (operand_push && dsp < 16) begin
                dstk[dsp] <= sel ? result : conv;
                dsp <= dsp + 1;
                n_push <= n_push + 1;
                if (n_push == 0) begin
                    first_mode <= int'(mode);
                    first_val  <= conv;
                end
                if (sel) begin
                    n_res <= n_res + 1;
                    if (n_res == 0) begin
                        first_res <= result;
                        t_res     <= cyc;
                    end
                end
            end
            if (operator_en) opr <= otop;
            if (operator_pop && osp > 0) osp <= osp - 1;
            if (operator_push && osp < 16) begin
                ostk[osp] <= cur;
                osp <= osp + 1;
            end
            if (result_en) result <= alu(op1, op2, opr);
        end
    end

    // ---------------- bench helpers ----------------
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code(input byte ch);
        case (ch)
            "#":     return C_HASH;
            "+":     return C_ADD;
            "-":     return C_SUB;
            "*":     return C_MUL;
            "/":     return C_DIV;
            default: return (ch >= "0" && ch <= "9") ? int'(ch - "0")
                                                      : C_BAD;
        endcase
    endfunction

    task automatic load(input string s);
        for (int i = 0; i < 128; i++) rom[i] = C_BAD;
        for (int i = 0; i < s.len() && i < 128; i++) rom[i] = code(s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic kick();
        do_reset();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done || error) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " finish"}, int'(done || error), 1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        load("#");
        repeat (2) @(negedge clk);

        do_reset();
        chk("reset outs", int'(outs), 0);
        chk("reset busy", int'(busy), 0);

        load("12+3#");
        kick();
        wait_end("12+3");
        chk("12+3 done", int'(done), 1);
        chk("12+3 error", int'(error), 0);
        chk("12+3 data", dtop, 15);
        chk("12+3 num1", n_num1, 1);
        chk("12+3 mode", first_mode, 1);
        chk("12+3 num", first_val, 12);
        chk("12+3 latency", t_res - t_op2, 3 + EXEC_CYCLES);

        load("9-4+2#");
        kick();
        wait_end("9-4+2");
        chk("9-4+2 done", int'(done), 1);
        chk("9-4+2 mid", first_res, 5);
        chk("9-4+2 data", dtop, 7);

        load("1234#");
        kick();
        wait_end("1234");
        chk("1234 error", int'(error), 1);
        chk("1234 index", int'(idx), 3);
        chk("1234 push", n_push, 0);

        load("+5#");
        kick();
        wait_end("+5");
        chk("+5 error", int'(error), 1);
        chk("+5 pop", n_pop, 0);

        load("#");
        kick();
        wait_end("hash");
        chk("hash error", int'(error), 1);
        chk("hash done", int'(done), 0);

        for (int i = 0; i < 128; i++) rom[i] = (i % 2 == 0) ? 1 : C_ADD;
        kick();
        wait_end("maxlen");
        chk("maxlen error", int'(error), 1);
        chk("maxlen done", int'(done), 0);

        begin
            int k;
            load("6*7#");
            kick();
            k = 0;
            while (!result_en && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("6*7 reach exec", int'(result_en), 1);
            rst = 1'b1;
            #1;
            chk("6*7 rst outs", int'(outs), 0);
            chk("6*7 rst busy", int'(busy), 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            wait_end("6*7 rerun");
            chk("6*7 rerun data", dtop, 42);
        end

        for (int t = 0; t < 20; t++) begin
            int n, pos, sum, term, pend, v, k, op, tmp;
            for (int i = 0; i < 128; i++) rom[i] = C_BAD;
            n = $urandom_range(1, 6);
            pos = 0; sum = 0; term = 0; pend = C_ADD; op = C_ADD;
            for (int j = 0; j < n; j++) begin
                if (j > 0) begin
                    op = $urandom_range(C_ADD, C_DIV);
                    rom[pos] = op;
                    pos++;
                end
                k = $urandom_range(1, 3);
                v = $urandom_range(0, (k == 1) ? 9 : ((k == 2) ? 99 : 999));
                if (j > 0 && op == C_DIV && v == 0) v = 1;
                tmp = v;
                for (int q = k - 1; q >= 0; q--) begin
                    rom[pos+q] = tmp % 10;
                    tmp = tmp / 10;
                end
                pos += k;
                if (j == 0) term = v;
                else if (op == C_MUL) term = term * v;
                else if (op == C_DIV) term = term / v;
                else begin
                    sum = (pend == C_ADD) ? sum + term : sum - term;
                    pend = op;
                    term = v;
                end
            end
            rom[pos] = C_HASH;
            sum = (pend == C_ADD) ? sum + term : sum - term;
            kick();
            wait_end($sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d done", t), int'(done), 1);
            chk($sformatf("rnd%0d data", t), dtop, sum);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
